// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a power-of-two FIFO. Frame: start, LSB-first data,
// optional parity, 1 or 2 stop bits. All outputs are registered.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 1,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_valid,
  input  logic [DATA_BITS-1:0]          i_data,
  output logic                          o_ready,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_count
);

  localparam int unsigned AddrW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW      = $clog2(CLKS_PER_BIT);
  // PARITY == 3 falls through to "no parity".
  localparam bit          HasParity = (PARITY == 1) || (PARITY == 2);
  localparam bit          OddParity = (PARITY == 2);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AddrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]       count_q;
  logic                 push, pop;

  state_e               state_q, state_d;
  logic [CntW-1:0]      clk_cnt_q, clk_cnt_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 bit_end;
  logic                 start_frame;

  // A full FIFO refuses writes even when a pop happens on the same edge.
  assign o_ready = (count_q != (AddrW + 1)'(FIFO_DEPTH));
  assign push    = i_valid && o_ready;
  assign o_count = count_q;
  assign o_tx    = tx_q;
  assign o_busy  = busy_q;

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= StIdle;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    par_d       = par_q;
    tx_d        = tx_q;
    busy_d      = busy_q;
    pop         = 1'b0;
    start_frame = 1'b0;
    bit_end     = (clk_cnt_q == CntW'(CLKS_PER_BIT - 1));

    if (state_q != StIdle) begin
      clk_cnt_d = bit_end ? '0 : clk_cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (count_q != '0) start_frame = 1'b1;
      end
      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_idx_d = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_idx_q == 4'(DATA_BITS - 1)) begin
            if (HasParity) begin
              state_d = StParity;
              tx_d    = par_q;
            end else begin
              state_d   = StStop;
              tx_d      = 1'b1;
              bit_idx_d = '0;
            end
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d   = StStop;
          tx_d      = 1'b1;
          bit_idx_d = '0;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (bit_idx_q == 4'(STOP_BITS - 1)) begin
            // Back-to-back frames: chain straight into the next start bit.
            if (count_q != '0) begin
              start_frame = 1'b1;
            end else begin
              state_d = StIdle;
              tx_d    = 1'b1;
              busy_d  = 1'b0;
            end
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (start_frame) begin
      pop       = 1'b1;
      state_d   = StStart;
      tx_d      = 1'b0;
      busy_d    = 1'b1;
      clk_cnt_d = '0;
      shift_d   = mem_q[rd_ptr_q];
      par_d     = (^mem_q[rd_ptr_q]) ^ OddParity;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench: three configurations share clock and reset; a line monitor
// per instance decodes frames and compares them against queued write data.
module tb_uart_tx_fifo;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] valid_v;
  logic [7:0] data0, data2;
  logic [6:0] data1;
  logic [2:0] ready_v, tx_v, busy_v;
  logic [2:0] cnt_v [3];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int frames_done [3] = '{0, 0, 0};
  int start_cyc   [3] = '{0, 0, 0};
  int last_gap    [3] = '{0, 0, 0};
  int contig      [3] = '{0, 0, 0};
  int busy_run    [3] = '{0, 0, 0};
  int busy_len    [3] = '{0, 0, 0};

  logic [8:0] sb0[$], sb1[$], sb2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid_v[0]), .i_data(data0),
    .o_ready(ready_v[0]), .o_tx(tx_v[0]), .o_busy(busy_v[0]), .o_count(cnt_v[0])
  );

  uart_tx_fifo #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) dut_odd7 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid_v[1]), .i_data(data1),
    .o_ready(ready_v[1]), .o_tx(tx_v[1]), .o_busy(busy_v[1]), .o_count(cnt_v[1])
  );

  uart_tx_fifo #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut_nopar (
    .i_clk(clk), .i_rst(rst), .i_valid(valid_v[2]), .i_data(data2),
    .o_ready(ready_v[2]), .o_tx(tx_v[2]), .o_busy(busy_v[2]), .o_count(cnt_v[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sb_size(input int idx);
    if (idx == 0) return sb0.size();
    else if (idx == 1) return sb1.size();
    else return sb2.size();
  endfunction

  task automatic sb_push(input int idx, input logic [8:0] d);
    if (idx == 0) sb0.push_back(d);
    else if (idx == 1) sb1.push_back(d);
    else sb2.push_back(d);
  endtask

  task automatic sb_pop(input int idx, output logic [8:0] d);
    d = '0;
    if (sb_size(idx) != 0) begin
      if (idx == 0) d = sb0.pop_front();
      else if (idx == 1) d = sb1.pop_front();
      else d = sb2.pop_front();
    end
  endtask

  // Busy-high run length, latched when busy falls.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (busy_v[i]) begin
        busy_run[i] <= busy_run[i] + 1;
      end else begin
        if (busy_run[i] != 0) busy_len[i] <= busy_run[i];
        busy_run[i] <= 0;
      end
    end
  end

  task automatic monitor(input int idx, input int db, input int pm, input int ns);
    logic [8:0]  w;
    logic [15:0] bits;
    logic        p;
    int          nb;
    bit          abort;
    int          last_end = -100;
    forever begin
      @(negedge clk);
      if (!rst && tx_v[idx] == 1'b0) begin
        check("sb_pending", 32'(sb_size(idx) != 0), 32'(1));
        sb_pop(idx, w);
        p = 1'b0;
        for (int i = 0; i < db; i++) p = p ^ w[i];
        if (pm == 2) p = ~p;
        bits = '1;
        bits[0] = 1'b0;
        nb = 1;
        for (int i = 0; i < db; i++) begin
          bits[nb] = w[i];
          nb++;
        end
        if (pm == 1 || pm == 2) begin
          bits[nb] = p;
          nb++;
        end
        nb = nb + ns;
        start_cyc[idx] = cyc;
        last_gap[idx]  = cyc - last_end;
        if (cyc - last_end == 1) contig[idx]++;
        abort = 1'b0;
        for (int b = 0; b < nb && !abort; b++) begin
          for (int c = 0; c < CPB && !abort; c++) begin
            if (b != 0 || c != 0) begin
              @(negedge clk);
              if (rst) abort = 1'b1;
            end
            if (!abort) begin
              check("tx_bit", 32'(tx_v[idx]), 32'(bits[b]));
              check("busy_in_frame", 32'(busy_v[idx]), 32'(1));
            end
          end
        end
        if (!abort) begin
          frames_done[idx]++;
          last_end = cyc;
        end
      end
    end
  endtask

  initial monitor(0, 8, 1, 1);
  initial monitor(1, 7, 2, 2);
  initial monitor(2, 8, 0, 1);

  task automatic wr(input int idx, input logic [8:0] d, input bit exp_acc, input int exp_cnt);
    valid_v[idx] = 1'b1;
    data0 = d[7:0];
    data1 = d[6:0];
    data2 = d[7:0];
    check("ready", 32'(ready_v[idx]), 32'(exp_acc));
    if (exp_acc) sb_push(idx, d);
    @(posedge clk);
    #1;
    valid_v[idx] = 1'b0;
    check("count", 32'(cnt_v[idx]), 32'(exp_cnt));
  endtask

  task automatic wait_frames(input int idx, input int n, input int budget);
    int t = 0;
    while (frames_done[idx] < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("frames_done", 32'(frames_done[idx]), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_cyc;
    int f0;
    int low_cycles;
    rst     = 1'b1;
    valid_v = '0;
    data0   = '0;
    data1   = '0;
    data2   = '0;
    #2;
    check("rst_tx", 32'(tx_v[0]), 32'(1));
    check("rst_busy", 32'(busy_v[0]), 32'(0));
    check("rst_count", 32'(cnt_v[0]), 32'(0));
    check("rst_ready", 32'(ready_v[0]), 32'(1));

    // First write on the first edge after release; 0x55 with even parity.
    @(negedge clk);
    rst = 1'b0;
    wr(0, 9'h055, 1'b1, 1);
    wr_cyc = cyc;
    wait_frames(0, 1, 200);
    check("start_latency", 32'(start_cyc[0] - wr_cyc), 32'(1));
    repeat (3) @(negedge clk);
    check("busy_len_8e1", 32'(busy_len[0]), 32'(44));
    check("idle_tx", 32'(tx_v[0]), 32'(1));
    check("idle_busy", 32'(busy_v[0]), 32'(0));

    // Five back-to-back writes fill the FIFO; the sixth is refused.
    wr(0, 9'h001, 1'b1, 1);
    wr(0, 9'h002, 1'b1, 1);
    wr(0, 9'h003, 1'b1, 2);
    wr(0, 9'h004, 1'b1, 3);
    wr(0, 9'h005, 1'b1, 4);
    wr(0, 9'h006, 1'b0, 4);
    wait_frames(0, 6, 5 * 44 + 100);
    check("contiguous_frames", 32'(contig[0]), 32'(4));

    // Write landing on the edge that ends the last stop bit.
    repeat (5) @(negedge clk);
    wr(0, 9'h0A3, 1'b1, 1);
    repeat (44) @(posedge clk);
    #1;
    wr(0, 9'h0C4, 1'b1, 1);
    wait_frames(0, 8, 200);
    check("one_idle_gap", 32'(last_gap[0]), 32'(2));

    // Reset during data bit 3 with two words queued.
    repeat (5) @(negedge clk);
    wr(0, 9'h032, 1'b1, 1);
    wr(0, 9'h05A, 1'b1, 1);
    wr(0, 9'h00F, 1'b1, 2);
    repeat (16) @(posedge clk);
    #2;
    rst = 1'b1;
    sb0.delete();
    #1;
    check("abort_tx", 32'(tx_v[0]), 32'(1));
    check("abort_busy", 32'(busy_v[0]), 32'(0));
    check("abort_count", 32'(cnt_v[0]), 32'(0));
    check("abort_ready", 32'(ready_v[0]), 32'(1));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    f0 = frames_done[0];
    low_cycles = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) low_cycles++;
    end
    check("no_frame_after_rst", 32'(low_cycles), 32'(0));
    check("frames_after_rst", 32'(frames_done[0]), 32'(f0));
    wr(0, 9'h096, 1'b1, 1);
    wait_frames(0, f0 + 1, 200);

    // Odd parity, 7 data bits, 2 stop bits; and no-parity 8N1.
    wr(1, 9'h003, 1'b1, 1);
    wr(2, 9'h0FF, 1'b1, 1);
    wait_frames(1, 1, 200);
    wait_frames(2, 1, 200);
    repeat (3) @(negedge clk);
    check("busy_len_7o2", 32'(busy_len[1]), 32'(44));
    check("busy_len_8n1", 32'(busy_len[2]), 32'(40));
    check("sb_empty0", 32'(sb_size(0)), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
